// File: rtl/fifo_mc_pkg.sv
// rtl/fifo_mc_pkg.sv - shared types, width helpers and legal runtime ranges for fifo_mc_with_sig
package fifo_mc_pkg;

  localparam int SIG_DEPTH_MIN  = 2;
  localparam int SIG_DEPTH_MAX  = 8;
  localparam int SIG_WIDTH_MIN  = 8;
  localparam int SIG_WIDTH_MAX  = 11;
  localparam int SIG_NUM_CH_MIN = 1;

  // Wide enough for any channel index or channel count this block will see.
  typedef logic [7:0] ch_idx_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr + 1 == depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mc_ch_ctrl.sv
// rtl/fifo_mc_ch_ctrl.sv - per-channel pointers, occupancy, status and sticky error flags
module fifo_mc_ch_ctrl
  import fifo_mc_pkg::*;
#(
  parameter int PW = 3,
  parameter int CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_push_sel,
  input  logic          i_pop_sel,
  input  logic          i_err_clr,
  input  logic [3:0]    i_depth,
  input  logic [3:0]    i_af_level,
  output logic [PW-1:0] o_wptr,
  output logic [PW-1:0] o_rptr,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_afull,
  output logic          o_push_acc,
  output logic          o_pop_acc,
  output logic          o_ovf,
  output logic          o_udf
);

  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_empty, r_full, r_afull, r_ovf, r_udf;
  logic          w_push_acc, w_pop_acc;

  // A full channel still takes a push when the same cycle frees a slot.
  assign w_pop_acc  = i_pop_sel && !r_empty;
  assign w_push_acc = i_push_sel && (!r_full || w_pop_acc);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_acc, w_pop_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_push_acc) r_wptr <= PW'(wrap_inc(int'(r_wptr), int'(i_depth)));
      if (w_pop_acc)  r_rptr <= PW'(wrap_inc(int'(r_rptr), int'(i_depth)));
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (32'(w_count_nxt) == 32'(i_depth));
      r_afull <= (32'(w_count_nxt) >= 32'(i_af_level));
      // A fresh error outranks a same-cycle clear.
      if (i_push_sel && !w_push_acc) r_ovf <= 1'b1;
      else if (i_err_clr)            r_ovf <= 1'b0;
      if (i_pop_sel && !w_pop_acc)   r_udf <= 1'b1;
      else if (i_err_clr)            r_udf <= 1'b0;
    end
  end

  assign o_wptr     = r_wptr;
  assign o_rptr     = r_rptr;
  assign o_count    = r_count;
  assign o_empty    = r_empty;
  assign o_full     = r_full;
  assign o_afull    = r_afull;
  assign o_push_acc = w_push_acc;
  assign o_pop_acc  = w_pop_acc;
  assign o_ovf      = r_ovf;
  assign o_udf      = r_udf;

endmodule

// File: rtl/fifo_mc_with_sig.sv
// rtl/fifo_mc_with_sig.sv - multi-channel runtime-configurable FIFO with shared flat storage
module fifo_mc_with_sig
  import fifo_mc_pkg::*;
#(
  parameter int max_FIFO_DEPTH = 8,
  parameter int max_FIFO_WIDTH = 11,
  parameter int max_NUM_CH     = 4,
  localparam int CHW = ch_w(max_NUM_CH),
  localparam int PW  = ptr_w(max_FIFO_DEPTH),
  localparam int CW  = cnt_w(max_FIFO_DEPTH),
  localparam int NW  = $clog2(max_NUM_CH) + 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [CHW-1:0]           push_ch,
  input  logic [max_FIFO_WIDTH-1:0] push_data,
  input  logic                     pop,
  input  logic [CHW-1:0]           pop_ch,
  output logic [max_FIFO_WIDTH-1:0] pop_data,
  output logic                     pop_valid,
  output logic [max_NUM_CH-1:0]    empty,
  output logic [max_NUM_CH-1:0]    full,
  output logic [max_NUM_CH-1:0]    afull,
  output logic [max_NUM_CH*CW-1:0] count,
  output logic [max_NUM_CH-1:0]    ovf,
  output logic [max_NUM_CH-1:0]    udf,
  output logic                     bad_ch,
  input  logic                     err_clr,
  input  logic [3:0]               sig_FIFO_DEPTH,
  input  logic [3:0]               sig_FIFO_WIDTH,
  input  logic [NW-1:0]            sig_NUM_CH,
  input  logic [3:0]               sig_AF_LEVEL
);

  logic [max_FIFO_WIDTH-1:0] r_mem [max_NUM_CH*max_FIFO_DEPTH];
  logic [max_FIFO_WIDTH-1:0] r_pop_data, w_mask;
  logic                      r_pop_valid, r_bad_ch;
  logic [PW-1:0]             w_wptr [max_NUM_CH];
  logic [PW-1:0]             w_rptr [max_NUM_CH];
  logic [max_NUM_CH-1:0]     w_push_acc, w_pop_acc;
  logic                      w_push_act, w_pop_act, w_bad_evt;
  logic [CHW+PW-1:0]         w_wr_addr, w_rd_addr;

  assign w_push_act = ch_idx_t'(push_ch) < ch_idx_t'(sig_NUM_CH);
  assign w_pop_act  = ch_idx_t'(pop_ch) < ch_idx_t'(sig_NUM_CH);
  assign w_bad_evt  = (push && !w_push_act) || (pop && !w_pop_act);

  for (genvar c = 0; c < max_NUM_CH; c++) begin : g_ch
    fifo_mc_ch_ctrl #(.PW(PW), .CW(CW)) u_ctrl (
      .i_clk      (clk),
      .i_rstn     (rstn),
      .i_push_sel (push && w_push_act && (push_ch == CHW'(c))),
      .i_pop_sel  (pop && w_pop_act && (pop_ch == CHW'(c))),
      .i_err_clr  (err_clr),
      .i_depth    (sig_FIFO_DEPTH),
      .i_af_level (sig_AF_LEVEL),
      .o_wptr     (w_wptr[c]),
      .o_rptr     (w_rptr[c]),
      .o_count    (count[c*CW +: CW]),
      .o_empty    (empty[c]),
      .o_full     (full[c]),
      .o_afull    (afull[c]),
      .o_push_acc (w_push_acc[c]),
      .o_pop_acc  (w_pop_acc[c]),
      .o_ovf      (ovf[c]),
      .o_udf      (udf[c])
    );
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < max_FIFO_WIDTH; i++) w_mask[i] = (i < int'(sig_FIFO_WIDTH));
  end

  assign w_wr_addr = {push_ch, w_wptr[push_ch]};
  assign w_rd_addr = {pop_ch, w_rptr[pop_ch]};

  // Storage is never read before it is written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (|w_push_acc) r_mem[w_wr_addr] <= push_data & w_mask;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pop_valid <= 1'b0;
      r_pop_data  <= '0;
      r_bad_ch    <= 1'b0;
    end else begin
      r_pop_valid <= |w_pop_acc;
      if (|w_pop_acc) r_pop_data <= r_mem[w_rd_addr];
      if (w_bad_evt)    r_bad_ch <= 1'b1;
      else if (err_clr) r_bad_ch <= 1'b0;
    end
  end

  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign bad_ch    = r_bad_ch;

endmodule

// File: tb/tb_fifo_mc_with_sig.sv
// tb/tb_fifo_mc_with_sig.sv - directed self-checking bench for fifo_mc_with_sig
module tb_fifo_mc_with_sig;
  import fifo_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [1:0]  push_ch = '0, pop_ch = '0;
  logic [10:0] push_data = '0;
  logic [3:0]  sig_FIFO_DEPTH = 4'd4, sig_FIFO_WIDTH = 4'd8, sig_AF_LEVEL = 4'd4;
  logic [2:0]  sig_NUM_CH = 3'd2;
  logic [10:0] pop_data;
  logic        pop_valid, bad_ch;
  logic [3:0]  empty, full, afull, ovf, udf;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  fifo_mc_with_sig dut (
    .clk(clk), .rstn(rstn), .push(push), .push_ch(push_ch), .push_data(push_data),
    .pop(pop), .pop_ch(pop_ch), .pop_data(pop_data), .pop_valid(pop_valid),
    .empty(empty), .full(full), .afull(afull), .count(count), .ovf(ovf), .udf(udf),
    .bad_ch(bad_ch), .err_clr(err_clr), .sig_FIFO_DEPTH(sig_FIFO_DEPTH),
    .sig_FIFO_WIDTH(sig_FIFO_WIDTH), .sig_NUM_CH(sig_NUM_CH), .sig_AF_LEVEL(sig_AF_LEVEL)
  );

  always #5 clk = ~clk;

  // Configuration inputs must stay stable and legal while out of reset.
  logic [14:0] prev_sig;
  logic        prev_rstn = 1'b0;
  always @(posedge clk) begin
    if (rstn && prev_rstn && {sig_FIFO_DEPTH, sig_FIFO_WIDTH, sig_NUM_CH, sig_AF_LEVEL} !== prev_sig) begin
      errors++;
      $display("FAIL sig_stable actual=%h required=%h", {sig_FIFO_DEPTH, sig_FIFO_WIDTH, sig_NUM_CH, sig_AF_LEVEL}, prev_sig);
    end
    if (rstn && (int'(sig_FIFO_DEPTH) < SIG_DEPTH_MIN || int'(sig_FIFO_DEPTH) > SIG_DEPTH_MAX ||
                 int'(sig_FIFO_WIDTH) < SIG_WIDTH_MIN || int'(sig_FIFO_WIDTH) > SIG_WIDTH_MAX ||
                 int'(sig_NUM_CH) < SIG_NUM_CH_MIN)) begin
      errors++;
      $display("FAIL sig_legal depth=%0d width=%0d nch=%0d", sig_FIFO_DEPTH, sig_FIFO_WIDTH, sig_NUM_CH);
    end
    prev_sig  = {sig_FIFO_DEPTH, sig_FIFO_WIDTH, sig_NUM_CH, sig_AF_LEVEL};
    prev_rstn = rstn;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_push(input logic [1:0] ch, input logic [10:0] d);
    push = 1'b1; push_ch = ch; push_data = d;
  endtask

  task automatic do_pop(input logic [1:0] ch);
    pop = 1'b1; pop_ch = ch;
  endtask

  task automatic cfg(input int depth, input int width, input int nch, input int af);
    idle();
    rstn = 1'b0;
    sig_FIFO_DEPTH = 4'(depth); sig_FIFO_WIDTH = 4'(width);
    sig_NUM_CH = 3'(nch); sig_AF_LEVEL = 4'(af);
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    cfg(4, 8, 2, 4);
    checks++; if (empty !== 4'b1111) begin errors++; $display("FAIL reset_empty actual=%b required=1111", empty); end
    checks++; if (full !== 4'b0000) begin errors++; $display("FAIL reset_full actual=%b required=0000", full); end
    checks++; if (afull !== 4'b0000) begin errors++; $display("FAIL reset_afull actual=%b required=0000", afull); end
    checks++; if (count !== 16'h0000) begin errors++; $display("FAIL reset_count actual=%h required=0000", count); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid actual=%b required=0", pop_valid); end
    checks++; if (pop_data !== 11'h000) begin errors++; $display("FAIL reset_pop_data actual=%h required=000", pop_data); end
    checks++; if ({ovf, udf, bad_ch} !== 9'h000) begin errors++; $display("FAIL reset_errs actual=%h required=000", {ovf, udf, bad_ch}); end
  endtask

  task automatic test_mask();
    do_push(2'd0, 11'h7A5); tick(); idle();
    checks++; if (count[3:0] !== 4'd1) begin errors++; $display("FAIL mask_count actual=%0d required=1", count[3:0]); end
    checks++; if (empty !== 4'b1110) begin errors++; $display("FAIL mask_empty actual=%b required=1110", empty); end
    do_pop(2'd0); tick(); idle();
    checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL mask_valid actual=%b required=1", pop_valid); end
    checks++; if (pop_data !== 11'h0A5) begin errors++; $display("FAIL mask_data actual=%h required=0a5", pop_data); end
    checks++; if (empty !== 4'b1111) begin errors++; $display("FAIL mask_empty2 actual=%b required=1111", empty); end
    tick();
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL mask_valid_idle actual=%b required=0", pop_valid); end
    checks++; if (pop_data !== 11'h0A5) begin errors++; $display("FAIL mask_hold actual=%h required=0a5", pop_data); end
  endtask

  task automatic test_overflow();
    cfg(2, 11, 2, 2);
    do_push(2'd1, 11'h111); tick();
    do_push(2'd1, 11'h222); tick();
    checks++; if (full !== 4'b0010) begin errors++; $display("FAIL ovf_full actual=%b required=0010", full); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_early actual=%b required=0000", ovf); end
    do_push(2'd1, 11'h333); tick(); idle();
    checks++; if (ovf !== 4'b0010) begin errors++; $display("FAIL ovf_set actual=%b required=0010", ovf); end
    checks++; if (count[7:4] !== 4'd2) begin errors++; $display("FAIL ovf_count actual=%0d required=2", count[7:4]); end
    do_pop(2'd1); tick();
    checks++; if (pop_data !== 11'h111 || pop_valid !== 1'b1) begin errors++; $display("FAIL ovf_pop1 actual=%h/%b required=111/1", pop_data, pop_valid); end
    tick(); idle();
    checks++; if (pop_data !== 11'h222 || pop_valid !== 1'b1) begin errors++; $display("FAIL ovf_pop2 actual=%h/%b required=222/1", pop_data, pop_valid); end
    checks++; if (full !== 4'b0000 || empty !== 4'b1111) begin errors++; $display("FAIL ovf_drained actual=%b/%b required=0000/1111", full, empty); end
  endtask

  task automatic test_full_wrap();
    cfg(4, 11, 2, 4);
    for (int i = 0; i < 4; i++) begin do_push(2'd0, 11'(11'h101 + i)); tick(); end
    checks++; if (full !== 4'b0001) begin errors++; $display("FAIL wrap_full actual=%b required=0001", full); end
    do_push(2'd0, 11'h105); do_pop(2'd0); tick(); idle();
    checks++; if (pop_valid !== 1'b1 || pop_data !== 11'h101) begin errors++; $display("FAIL wrap_simul actual=%h/%b required=101/1", pop_data, pop_valid); end
    checks++; if (count[3:0] !== 4'd4 || ovf !== 4'b0000) begin errors++; $display("FAIL wrap_count actual=%0d/%b required=4/0000", count[3:0], ovf); end
    do_pop(2'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pop_valid !== 1'b1 || pop_data !== 11'(11'h102 + i)) begin errors++; $display("FAIL wrap_pop%0d actual=%h required=%h", i, pop_data, 11'h102 + i); end
    end
    idle();
    checks++; if (empty !== 4'b1111) begin errors++; $display("FAIL wrap_empty actual=%b required=1111", empty); end
  endtask

  task automatic test_underflow();
    do_push(2'd1, 11'h055); do_pop(2'd1); tick(); idle();
    checks++; if (udf !== 4'b0010) begin errors++; $display("FAIL udf_set actual=%b required=0010", udf); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL udf_valid actual=%b required=0", pop_valid); end
    checks++; if (count[7:4] !== 4'd1) begin errors++; $display("FAIL udf_count actual=%0d required=1", count[7:4]); end
    err_clr = 1'b1; do_pop(2'd0); tick(); idle();
    checks++; if (udf !== 4'b0001) begin errors++; $display("FAIL udf_clr_race actual=%b required=0001", udf); end
    err_clr = 1'b1; tick(); idle();
    checks++; if (udf !== 4'b0000) begin errors++; $display("FAIL udf_clr actual=%b required=0000", udf); end
    do_pop(2'd1); tick(); idle();
    checks++; if (pop_data !== 11'h055 || pop_valid !== 1'b1) begin errors++; $display("FAIL udf_pushed actual=%h/%b required=055/1", pop_data, pop_valid); end
  endtask

  task automatic test_bad_ch_afull();
    cfg(8, 11, 2, 3);
    do_push(2'd3, 11'h077); tick(); idle();
    checks++; if (bad_ch !== 1'b1) begin errors++; $display("FAIL bad_set actual=%b required=1", bad_ch); end
    checks++; if (count !== 16'h0000 || empty !== 4'b1111) begin errors++; $display("FAIL bad_nochange actual=%h/%b required=0000/1111", count, empty); end
    err_clr = 1'b1; tick(); idle();
    checks++; if (bad_ch !== 1'b0) begin errors++; $display("FAIL bad_clr actual=%b required=0", bad_ch); end
    do_push(2'd0, 11'h0A1); tick();
    do_push(2'd0, 11'h0A2); tick();
    checks++; if (afull !== 4'b0000) begin errors++; $display("FAIL afull_two actual=%b required=0000", afull); end
    do_push(2'd0, 11'h0A3); tick(); idle();
    checks++; if (afull !== 4'b0001 || count[3:0] !== 4'd3) begin errors++; $display("FAIL afull_three actual=%b/%0d required=0001/3", afull, count[3:0]); end
    do_pop(2'd0); tick(); idle();
    checks++; if (afull !== 4'b0000 || pop_data !== 11'h0A1) begin errors++; $display("FAIL afull_pop actual=%b/%h required=0000/0a1", afull, pop_data); end
  endtask

  task automatic test_reset_mid();
    do_push(2'd0, 11'h0A4); tick(); idle();
    checks++; if (count[3:0] !== 4'd3) begin errors++; $display("FAIL mid_count actual=%0d required=3", count[3:0]); end
    rstn = 1'b0; do_pop(2'd0); tick(); idle();
    checks++; if (pop_valid !== 1'b0 || count !== 16'h0000 || empty !== 4'b1111) begin errors++; $display("FAIL mid_reset actual=%b/%h/%b required=0/0000/1111", pop_valid, count, empty); end
    rstn = 1'b1; do_pop(2'd0); tick(); idle();
    checks++; if (udf !== 4'b0001 || pop_valid !== 1'b0) begin errors++; $display("FAIL mid_udf actual=%b/%b required=0001/0", udf, pop_valid); end
  endtask

  task automatic test_back_to_back();
    cfg(8, 11, 4, 8);
    do_push(2'd2, 11'h2AA); tick();
    do_push(2'd3, 11'h3BB); do_pop(2'd2); tick();
    checks++; if (pop_data !== 11'h2AA || count !== 16'h1000) begin errors++; $display("FAIL b2b_1 actual=%h/%h required=2aa/1000", pop_data, count); end
    do_push(2'd2, 11'h2CC); do_pop(2'd3); tick();
    checks++; if (pop_data !== 11'h3BB || count !== 16'h0100) begin errors++; $display("FAIL b2b_2 actual=%h/%h required=3bb/0100", pop_data, count); end
    push = 1'b0; do_pop(2'd2); tick(); idle();
    checks++; if (pop_data !== 11'h2CC || pop_valid !== 1'b1 || empty !== 4'b1111) begin errors++; $display("FAIL b2b_3 actual=%h/%b/%b required=2cc/1/1111", pop_data, pop_valid, empty); end
  endtask

  initial begin
    test_reset();
    test_mask();
    test_overflow();
    test_full_wrap();
    test_underflow();
    test_bad_ch_afull();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
